// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one 8-lane DRAM port between NUM_REQ requesters.
// Ownership is transaction-grained and handed out round-robin. The owner keeps
// the port while it holds lock or still has accesses in flight. Read responses
// are steered back to the requester that issued them. All DRAM-side outputs are
// registered.
module dram_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ*8-1:0]   req_en,
    input  logic [NUM_REQ-1:0]     req_rdwr,
    input  logic [NUM_REQ*512-1:0] req_addr,
    input  logic [NUM_REQ*64-1:0]  req_data,
    input  logic [NUM_REQ-1:0]     req_lock,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   stall,
    output logic [NUM_REQ*8-1:0]   rsp_valid,
    output logic [63:0]            rsp_data,
    output logic                   err,
    output logic [7:0]             dram_en,
    output logic                   dram_rdwr,
    output logic [511:0]           dram_addr,
    output logic [63:0]            dram_data_out,
    input  logic [63:0]            dram_data_in,
    input  logic [7:0]             dram_valid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] MAX_OUT_W = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   own_q, own_d;        // current owner, kept as last owner in DRAIN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               err_q;

    logic [7:0]         dram_en_q;
    logic               dram_rdwr_q;
    logic [511:0]       dram_addr_q;
    logic [63:0]        dram_data_q;

    // Per-requester activity and the rotated scan order starting at rr_ptr.
    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] rot_active;
    logic [IDX_W:0]     rot_sum [NUM_REQ];
    logic [IDX_W-1:0]   rot_idx [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign active[gi]     = (|req_en[8*gi +: 8]) | req_lock[gi];
            assign rot_sum[gi]    = {1'b0, rr_ptr_q} + (IDX_W + 1)'(gi);
            assign rot_idx[gi]    = (rot_sum[gi] >= NUM_REQ_W) ?
                                    IDX_W'(rot_sum[gi] - NUM_REQ_W) :
                                    rot_sum[gi][IDX_W-1:0];
            assign rot_active[gi] = active[rot_idx[gi]];
        end
    endgenerate

    // Owner's request fields.
    logic [7:0]   own_en;
    logic         own_rdwr;
    logic [511:0] own_addr;
    logic [63:0]  own_data;
    logic         own_lock;

    assign own_en   = req_en[8*own_q +: 8];
    assign own_rdwr = req_rdwr[own_q];
    assign own_addr = req_addr[512*own_q +: 512];
    assign own_data = req_data[64*own_q +: 64];
    assign own_lock = req_lock[own_q];

    logic rsp_any, rsp_dec, issue, stray, route_ok;

    assign rsp_any  = |dram_valid;
    assign rsp_dec  = rsp_any & (out_cnt_q != '0);
    // A response in this cycle frees a slot, so a full window only stalls
    // when nothing is coming back.
    assign stall    = (out_cnt_q == MAX_OUT_W) & ~rsp_any;
    assign issue    = (state_q == OWNED) & (|own_en) & ~stall;
    assign stray    = rsp_any & (out_cnt_q == '0);
    assign route_ok = (state_q != IDLE) & (out_cnt_q != '0);

    // Outstanding-access counter update; issue and response cancel out.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (issue && !rsp_dec) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!issue && rsp_dec) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    // Round-robin pick: first active requester at or after rr_ptr.
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_active[k]) begin
                pick_found = 1'b1;
                pick_idx   = rot_idx[k];
            end
        end
    end

    // Ownership FSM: next state, grant, owner and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        own_d    = own_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    own_d   = pick_idx;
                end
            end
            OWNED: begin
                if (!own_lock && !(|own_en)) begin
                    gnt_d    = '0;
                    rr_ptr_d = (own_q == LAST_IDX) ? '0 : own_q + 1'b1;
                    state_d  = (out_cnt_d == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            own_q     <= '0;
            rr_ptr_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            own_q     <= own_d;
            rr_ptr_q  <= rr_ptr_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Sticky error on a response that nothing is waiting for.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (stray) begin
            err_q <= 1'b1;
        end
    end

    // Registered DRAM command; enables drop when idle, the rest holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            dram_en_q   <= '0;
            dram_rdwr_q <= 1'b0;
            dram_addr_q <= '0;
            dram_data_q <= '0;
        end else if (issue) begin
            dram_en_q   <= own_en;
            dram_rdwr_q <= own_rdwr;
            dram_addr_q <= own_addr;
            dram_data_q <= own_data;
        end else begin
            dram_en_q   <= '0;
        end
    end

    // Response steering: only the (last) owner's slice sees dram_valid.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[8*gi +: 8] =
                (route_ok && (own_q == IDX_W'(gi))) ? dram_valid : 8'h00;
        end
    endgenerate

    assign rsp_data      = dram_data_in;
    assign gnt           = gnt_q;
    assign err           = err_q;
    assign dram_en       = dram_en_q;
    assign dram_rdwr     = dram_rdwr_q;
    assign dram_addr     = dram_addr_q;
    assign dram_data_out = dram_data_q;

endmodule
